// File: rtl/id_stage_pipelined_pkg.sv
// Shared decode constants for the ID stage: modes, opcodes,
// ALU command encodings, condition codes and status-flag positions.
package id_stage_pipelined_pkg;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_NOP  = 4'b0000;
    localparam logic [3:0] EXE_MOV  = 4'b0001;
    localparam logic [3:0] EXE_ADD  = 4'b0010;
    localparam logic [3:0] EXE_ADC  = 4'b0011;
    localparam logic [3:0] EXE_SUB  = 4'b0100;
    localparam logic [3:0] EXE_SBC  = 4'b0101;
    localparam logic [3:0] EXE_AND  = 4'b0110;
    localparam logic [3:0] EXE_ORR  = 4'b0111;
    localparam logic [3:0] EXE_EOR  = 4'b1000;
    localparam logic [3:0] EXE_MVN  = 4'b1001;
    // Loads and stores reuse the adder for address generation.
    localparam logic [3:0] EXE_LDST = EXE_ADD;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_stage_pipelined_decode_ctrl.sv
// Combinational instruction decoder: control bundle, source
// register selection and source-usage flags.
module decode_ctrl
    import id_stage_pipelined_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic       imm_i,
    input  logic [3:0] opcode_i,
    input  logic       s_i,
    input  logic [3:0] rn_i,
    input  logic [3:0] rd_i,
    input  logic [3:0] rm_i,
    output ctrl_t      ctrl_o,
    output logic [3:0] src1_o,
    output logic [3:0] src2_o,
    output logic       two_src_o,
    output logic       has_src1_o
);

    logic is_str;

    assign is_str    = (mode_i == MODE_MEM) && !s_i;
    assign src1_o    = rn_i;
    // A store reads its data register through the second port.
    assign src2_o    = is_str ? rd_i : rm_i;
    assign two_src_o = !imm_i || is_str;

    always_comb begin
        ctrl_o     = CTRL_NOP;
        has_src1_o = 1'b1;
        unique case (mode_i)
            MODE_ALU: begin
                ctrl_o.wb_en = 1'b1;
                ctrl_o.s     = s_i;
                unique case (opcode_i)
                    OP_MOV: begin
                        ctrl_o.exe_cmd = EXE_MOV;
                        has_src1_o     = 1'b0;
                    end
                    OP_MVN: begin
                        ctrl_o.exe_cmd = EXE_MVN;
                        has_src1_o     = 1'b0;
                    end
                    OP_ADD: ctrl_o.exe_cmd = EXE_ADD;
                    OP_ADC: ctrl_o.exe_cmd = EXE_ADC;
                    OP_SUB: ctrl_o.exe_cmd = EXE_SUB;
                    OP_SBC: ctrl_o.exe_cmd = EXE_SBC;
                    OP_AND: ctrl_o.exe_cmd = EXE_AND;
                    OP_ORR: ctrl_o.exe_cmd = EXE_ORR;
                    OP_EOR: ctrl_o.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        ctrl_o.exe_cmd = EXE_SUB;
                        ctrl_o.wb_en   = 1'b0;
                        ctrl_o.s       = 1'b1;
                    end
                    OP_TST: begin
                        ctrl_o.exe_cmd = EXE_AND;
                        ctrl_o.wb_en   = 1'b0;
                        ctrl_o.s       = 1'b1;
                    end
                    default: ctrl_o = CTRL_NOP;
                endcase
            end
            MODE_MEM: begin
                ctrl_o.exe_cmd = EXE_LDST;
                if (s_i) begin
                    ctrl_o.mem_r_en = 1'b1;
                    ctrl_o.wb_en    = 1'b1;
                end else begin
                    ctrl_o.mem_w_en = 1'b1;
                end
            end
            MODE_BR: begin
                ctrl_o.b   = 1'b1;
                has_src1_o = 1'b0;
            end
            default: ctrl_o = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// ID stage: decode, condition check, register file with optional
// write-back forwarding, and the ID/EX pipeline register.
module id_stage_pipelined
    import id_stage_pipelined_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        sr,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              has_src1,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic [3:0]        ex_exe_cmd,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_operand,
    output logic [23:0]       ex_signed_imm_24,
    output logic [3:0]        ex_dest
);

    localparam logic [4:0] NREGS = 5'(NUM_REGS);

    ctrl_t dec_ctrl;
    logic  cond_ok;
    logic  n_f, z_f, c_f, v_f;

    decode_ctrl u_dec (
        .mode_i     (instr_in[27:26]),
        .imm_i      (instr_in[25]),
        .opcode_i   (instr_in[24:21]),
        .s_i        (instr_in[20]),
        .rn_i       (instr_in[19:16]),
        .rd_i       (instr_in[15:12]),
        .rm_i       (instr_in[3:0]),
        .ctrl_o     (dec_ctrl),
        .src1_o     (src1),
        .src2_o     (src2),
        .two_src_o  (two_src),
        .has_src1_o (has_src1)
    );

    assign n_f = sr[SR_N];
    assign z_f = sr[SR_Z];
    assign c_f = sr[SR_C];
    assign v_f = sr[SR_V];

    always_comb begin
        cond_ok = 1'b0;
        unique case (instr_in[31:28])
            COND_EQ: cond_ok = z_f;
            COND_NE: cond_ok = !z_f;
            COND_CS: cond_ok = c_f;
            COND_CC: cond_ok = !c_f;
            COND_MI: cond_ok = n_f;
            COND_PL: cond_ok = !n_f;
            COND_VS: cond_ok = v_f;
            COND_VC: cond_ok = !v_f;
            COND_HI: cond_ok = c_f && !z_f;
            COND_LS: cond_ok = !c_f || z_f;
            COND_GE: cond_ok = (n_f == v_f);
            COND_LT: cond_ok = (n_f != v_f);
            COND_GT: cond_ok = !z_f && (n_f == v_f);
            COND_LE: cond_ok = z_f || (n_f != v_f);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Entries at or above NUM_REGS are never written, so they read 0.
    logic [DATA_W-1:0] rf_q [16];
    logic              wb_live;
    logic [DATA_W-1:0] rd_rn, rd_rm;

    assign wb_live = wb_en && ({1'b0, wb_dest} < NREGS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_live) begin
            rf_q[wb_dest] <= wb_value;
        end
    end

    always_comb begin
        rd_rn = rf_q[src1];
        rd_rm = rf_q[src2];
        if (WB_BYPASS && wb_live && (wb_dest == src1)) begin
            rd_rn = wb_value;
        end
        if (WB_BYPASS && wb_live && (wb_dest == src2)) begin
            rd_rm = wb_value;
        end
    end

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rn_q, rn_d;
    logic [DATA_W-1:0] rm_q, rm_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              imm_q, imm_d;
    logic [11:0]       shop_q, shop_d;
    logic [23:0]       simm_q, simm_d;
    logic [3:0]        dest_q, dest_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        shop_d  = shop_q;
        simm_d  = simm_q;
        dest_d  = dest_q;
        priority case (1'b1)
            flush: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_NOP;
                rn_d    = '0;
                rm_d    = '0;
                pc_d    = '0;
                imm_d   = 1'b0;
                shop_d  = '0;
                simm_d  = '0;
                dest_d  = '0;
            end
            !stall: begin
                valid_d = in_valid;
                ctrl_d  = (in_valid && cond_ok) ? dec_ctrl : CTRL_NOP;
                rn_d    = rd_rn;
                rm_d    = rd_rm;
                pc_d    = pc_in;
                imm_d   = instr_in[25];
                shop_d  = instr_in[11:0];
                simm_d  = instr_in[23:0];
                dest_d  = instr_in[15:12];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            rn_q    <= '0;
            rm_q    <= '0;
            pc_q    <= '0;
            imm_q   <= 1'b0;
            shop_q  <= '0;
            simm_q  <= '0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            shop_q  <= shop_d;
            simm_q  <= simm_d;
            dest_q  <= dest_d;
        end
    end

    assign ex_valid         = valid_q;
    assign ex_wb_en         = ctrl_q.wb_en;
    assign ex_mem_r_en      = ctrl_q.mem_r_en;
    assign ex_mem_w_en      = ctrl_q.mem_w_en;
    assign ex_b             = ctrl_q.b;
    assign ex_s             = ctrl_q.s;
    assign ex_exe_cmd       = ctrl_q.exe_cmd;
    assign ex_val_rn        = rn_q;
    assign ex_val_rm        = rm_q;
    assign ex_pc            = pc_q;
    assign ex_imm           = imm_q;
    assign ex_shift_operand = shop_q;
    assign ex_signed_imm_24 = simm_q;
    assign ex_dest          = dest_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: a bypassing 16-register instance and a
// non-bypassing 8-register instance checked against an ISA-level model.
module tb_id_stage_pipelined;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r;
        logic        mem_w;
        logic        b;
        logic        s;
        logic [3:0]  cmd;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] pc;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, wb_en;
    logic [31:0] instr_in, pc_in, wb_value;
    logic [3:0]  sr, wb_dest;

    always #5 clk = ~clk;

    logic [3:0]  s1a, s2a, s1b, s2b;
    logic        tsa, hsa, tsb, hsb;
    logic        va, wba, mra, mwa, ba, sa, imma;
    logic        vb, wbb, mrb, mwb, bb, sb, immb;
    logic [3:0]  cmda, desta, cmdb, destb;
    logic [31:0] rna, rma, pca, rnb, rmb, pcb;
    logic [11:0] shopa, shopb;
    logic [23:0] simma, simmb;
    ex_t         got1, got0;

    id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16), .WB_BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in(instr_in),
        .pc_in(pc_in), .sr(sr), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(s1a), .src2(s2a), .two_src(tsa), .has_src1(hsa),
        .ex_valid(va), .ex_wb_en(wba), .ex_mem_r_en(mra),
        .ex_mem_w_en(mwa), .ex_b(ba), .ex_s(sa), .ex_exe_cmd(cmda),
        .ex_val_rn(rna), .ex_val_rm(rma), .ex_pc(pca), .ex_imm(imma),
        .ex_shift_operand(shopa), .ex_signed_imm_24(simma),
        .ex_dest(desta)
    );

    id_stage_pipelined #(.DATA_W(32), .NUM_REGS(8), .WB_BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in(instr_in),
        .pc_in(pc_in), .sr(sr), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(s1b), .src2(s2b), .two_src(tsb), .has_src1(hsb),
        .ex_valid(vb), .ex_wb_en(wbb), .ex_mem_r_en(mrb),
        .ex_mem_w_en(mwb), .ex_b(bb), .ex_s(sb), .ex_exe_cmd(cmdb),
        .ex_val_rn(rnb), .ex_val_rm(rmb), .ex_pc(pcb), .ex_imm(immb),
        .ex_shift_operand(shopb), .ex_signed_imm_24(simmb),
        .ex_dest(destb)
    );

    assign got1 = {va, wba, mra, mwa, ba, sa, cmda, rna, rma, pca,
                   imma, shopa, simma, desta};
    assign got0 = {vb, wbb, mrb, mwb, bb, sb, cmdb, rnb, rmb, pcb,
                   immb, shopb, simmb, destb};

    int          n_cmp = 0;
    int          n_bad = 0;
    ex_t         exp1, exp0;
    logic [31:0] rf1 [16];
    logic [31:0] rf0 [16];

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [3:0] idx,
            input logic [31:0] rf [16], input int nregs, input bit byp);
        if (int'(idx) >= nregs) return 32'h0;
        if (byp && wb_en && wb_dest == idx) return wb_value;
        return rf[idx];
    endfunction

    function automatic ex_t ref_next(input ex_t cur,
            input logic [31:0] rf [16], input int nregs, input bit byp);
        ex_t n;
        logic [1:0] mode;
        logic [3:0] op, sel2;
        bit str;
        if (flush) return '0;
        if (stall) return cur;
        mode = instr_in[27:26];
        op = instr_in[24:21];
        str = (mode == 2'd1) && !instr_in[20];
        sel2 = str ? instr_in[15:12] : instr_in[3:0];
        n = '0;
        n.valid = in_valid;
        n.rn = ref_read(instr_in[19:16], rf, nregs, byp);
        n.rm = ref_read(sel2, rf, nregs, byp);
        n.pc = pc_in;
        n.imm = instr_in[25];
        n.shop = instr_in[11:0];
        n.simm = instr_in[23:0];
        n.dest = instr_in[15:12];
        if (in_valid && cond_pass(instr_in[31:28], sr)) begin
            if (mode == 2'd0) begin
                n.s = instr_in[20];
                n.wb_en = 1'b1;
                case (op)
                    4'hD: n.cmd = 4'd1;
                    4'hF: n.cmd = 4'd9;
                    4'h4: n.cmd = 4'd2;
                    4'h5: n.cmd = 4'd3;
                    4'h2: n.cmd = 4'd4;
                    4'h6: n.cmd = 4'd5;
                    4'h0: n.cmd = 4'd6;
                    4'hC: n.cmd = 4'd7;
                    4'h1: n.cmd = 4'd8;
                    4'hA: begin n.cmd = 4'd4; n.wb_en = 1'b0; n.s = 1'b1; end
                    4'h8: begin n.cmd = 4'd6; n.wb_en = 1'b0; n.s = 1'b1; end
                    default: begin n.wb_en = 1'b0; n.s = 1'b0; end
                endcase
            end else if (mode == 2'd1) begin
                n.cmd = 4'd2;
                if (instr_in[20]) begin
                    n.mem_r = 1'b1;
                    n.wb_en = 1'b1;
                end else begin
                    n.mem_w = 1'b1;
                end
            end else if (mode == 2'd2) begin
                n.b = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        exp1 = '0;
        exp0 = '0;
        for (int i = 0; i < 16; i++) begin
            rf1[i] = 32'h0;
            rf0[i] = 32'h0;
        end
    endtask

    task automatic tick();
        if (!rst) begin
            model_reset();
        end else begin
            exp1 = ref_next(exp1, rf1, 16, 1'b1);
            exp0 = ref_next(exp0, rf0, 8, 1'b0);
            if (wb_en) begin
                rf1[wb_dest] = wb_value;
                if (wb_dest < 4'd8) rf0[wb_dest] = wb_value;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; instr_in = 32'h0; pc_in = 32'h0;
        sr = 4'h0; stall = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_dest = 4'h0; wb_value = 32'h0;
        model_reset();
        #3;
        n_cmp++;
        if (got1 !== '0 || got0 !== '0) begin
            n_bad++;
            $display("FAIL reset_init got1=%h got0=%h want 0", got1, got0);
        end
        in_valid = 1'b1; instr_in = 32'hE0831003; pc_in = 32'h40;
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD;
        tick();
        tick();
        n_cmp++;
        if (got1 !== '0 || got0 !== '0) begin
            n_bad++;
            $display("FAIL reset_held got1=%h got0=%h want 0", got1, got0);
        end
        rst = 1'b1; in_valid = 1'b0; wb_en = 1'b0;
    endtask

    task automatic test_add();
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h1234;
        tick();
        wb_en = 1'b0; in_valid = 1'b1; instr_in = 32'hE0831003;
        pc_in = 32'h104;
        tick();
        n_cmp++;
        if (rna !== 32'h1234 || rma !== 32'h1234 || cmda !== 4'b0010 ||
            wba !== 1'b1 || desta !== 4'd1 || va !== 1'b1) begin
            n_bad++;
            $display("FAIL add rn=%h rm=%h cmd=%b wb=%b dest=%0d want 1234/1234/0010/1/1",
                     rna, rma, cmda, wba, desta);
        end
        n_cmp++;
        if (got1 !== exp1) begin
            n_bad++;
            $display("FAIL add_model got=%h want=%h", got1, exp1);
        end
    endtask

    task automatic test_bypass();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
        tick();
        wb_value = 32'hAA; in_valid = 1'b1; instr_in = 32'hE0421003;
        tick();
        n_cmp++;
        if (rna !== 32'hAA || rnb !== 32'h55) begin
            n_bad++;
            $display("FAIL bypass rn_byp=%h rn_nobyp=%h want aa/55", rna, rnb);
        end
        in_valid = 1'b0; wb_dest = 4'd9; wb_value = 32'h99;
        tick();
        wb_en = 1'b0; in_valid = 1'b1; instr_in = 32'hE0890009;
        tick();
        n_cmp++;
        if (rna !== 32'h99 || rnb !== 32'h0 || rmb !== 32'h0) begin
            n_bad++;
            $display("FAIL idx_range rn16=%h rn8=%h rm8=%h want 99/0/0",
                     rna, rnb, rmb);
        end
        n_cmp++;
        if (got1 !== exp1 || got0 !== exp0) begin
            n_bad++;
            $display("FAIL bypass_model got1=%h want=%h got0=%h want=%h",
                     got1, exp1, got0, exp0);
        end
    endtask

    task automatic test_cond();
        sr = 4'b0100; in_valid = 1'b1;
        instr_in = 32'h1A000010;
        tick();
        n_cmp++;
        if (ba !== 1'b0 || va !== 1'b1) begin
            n_bad++;
            $display("FAIL bne_z b=%b valid=%b want 0/1", ba, va);
        end
        instr_in = 32'h0A000010;
        tick();
        n_cmp++;
        if (ba !== 1'b1 || got1 !== exp1) begin
            n_bad++;
            $display("FAIL beq_z b=%b got=%h want=%h", ba, got1, exp1);
        end
        instr_in = 32'hF0831003;
        tick();
        n_cmp++;
        if ({wba, mra, mwa, ba, sa, cmda} !== 9'h0 || got1 !== exp1) begin
            n_bad++;
            $display("FAIL cond_nv ctrl=%h got=%h want=%h",
                     {wba, mra, mwa, ba, sa, cmda}, got1, exp1);
        end
        sr = 4'h0;
    endtask

    task automatic test_stall_flush();
        ex_t held;
        in_valid = 1'b1; instr_in = 32'hE1812003; pc_in = 32'h200;
        tick();
        held = exp1;
        n_cmp++;
        if (got1 !== held) begin
            n_bad++;
            $display("FAIL orr_load got=%h want=%h", got1, held);
        end
        stall = 1'b1; wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h5555;
        for (int k = 0; k < 3; k++) begin
            instr_in = $urandom; pc_in = $urandom;
            tick();
            n_cmp++;
            if (got1 !== held || got0 !== exp0) begin
                n_bad++;
                $display("FAIL stall_hold cyc=%0d got=%h want=%h", k, got1, held);
            end
        end
        stall = 1'b0; wb_en = 1'b0; instr_in = 32'hE0850005;
        tick();
        n_cmp++;
        if (rna !== 32'h5555 || rma !== 32'h5555 || rnb !== 32'h5555) begin
            n_bad++;
            $display("FAIL stall_write rn=%h rm=%h rn8=%h want 5555", rna, rma, rnb);
        end
        flush = 1'b1; stall = 1'b1;
        tick();
        n_cmp++;
        if (va !== 1'b0 || got1 !== '0 || got0 !== '0) begin
            n_bad++;
            $display("FAIL flush_over_stall got1=%h got0=%h want 0", got1, got0);
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_sources();
        instr_in = 32'hE4014000; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (s2a !== 4'd4 || tsa !== 1'b1 || s1a !== 4'd1) begin
            n_bad++;
            $display("FAIL str_src src1=%0d src2=%0d two=%b want 1/4/1", s1a, s2a, tsa);
        end
        tick();
        n_cmp++;
        if (mwa !== 1'b1 || mra !== 1'b0 || got1 !== exp1) begin
            n_bad++;
            $display("FAIL str_ex mem_w=%b got=%h want=%h", mwa, got1, exp1);
        end
        instr_in = 32'hE3A00005;
        #1;
        n_cmp++;
        if (hsa !== 1'b0 || tsa !== 1'b0) begin
            n_bad++;
            $display("FAIL mov_src has_src1=%b two=%b want 0/0", hsa, tsa);
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [3:0] e1, e2;
        bit str, e_two, e_has;
        for (int k = 0; k < 400; k++) begin
            instr_in = $urandom; pc_in = $urandom; sr = 4'($urandom);
            in_valid = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            wb_en = 1'($urandom); wb_dest = 4'($urandom);
            wb_value = $urandom;
            #1;
            m = instr_in[27:26];
            str = (m == 2'd1) && !instr_in[20];
            e1 = instr_in[19:16];
            e2 = str ? instr_in[15:12] : instr_in[3:0];
            e_two = !instr_in[25] || str;
            e_has = !(((m == 2'd0) && (instr_in[24:21] == 4'hD ||
                      instr_in[24:21] == 4'hF)) || m == 2'd2);
            n_cmp++;
            if ({s1a, s2a, tsa, hsa} !== {e1, e2, e_two, e_has} ||
                {s1b, s2b, tsb, hsb} !== {e1, e2, e_two, e_has}) begin
                n_bad++;
                $display("FAIL rand_src k=%0d instr=%h got=%h want=%h", k, instr_in,
                         {s1a, s2a, tsa, hsa}, {e1, e2, e_two, e_has});
            end
            tick();
            n_cmp++;
            if (got1 !== exp1 || got0 !== exp0) begin
                n_bad++;
                $display("FAIL rand_ex k=%0d got1=%h want=%h got0=%h want=%h",
                         k, got1, exp1, got0, exp0);
            end
        end
        stall = 1'b0; flush = 1'b0; wb_en = 1'b0; sr = 4'h0;
    endtask

    task automatic test_async_reset();
        wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
        in_valid = 1'b1; instr_in = 32'hE1812003;
        tick();
        wb_en = 1'b0; stall = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (got1 !== '0 || got0 !== '0) begin
            n_bad++;
            $display("FAIL async_reset got1=%h got0=%h want 0", got1, got0);
        end
        #1;
        rst = 1'b1; stall = 1'b0; in_valid = 1'b1;
        instr_in = 32'hE0870007; pc_in = 32'h300;
        tick();
        n_cmp++;
        if (va !== 1'b1 || rna !== 32'h0 || got1 !== exp1) begin
            n_bad++;
            $display("FAIL post_reset_load got=%h want=%h", got1, exp1);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bypass();
        test_cond();
        test_stall_flush();
        test_sources();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
ID_STAGE_PIPELINED -- requirements
Module: id_stage_pipelined

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath and register width (16..64).
REQ-002 The block SHALL have parameter NUM_REGS, default 16, register-file depth (2..16); indices at or above NUM_REGS read 0 and ignore writes.
REQ-003 The block SHALL have parameter WB_BYPASS, default 1; 1 enables same-cycle write-back-to-read forwarding, 0 disables it.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning (clock and reset first).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instr_in/pc_in are valid this cycle.
- instr_in  in  32  ARM instruction word.
- pc_in  in  DATA_W  PC+4 of the instruction.
- sr  in  4  status flags {N,Z,C,V}.
- stall  in  1  hazard stall: hold the ID/EX register.
- flush  in  1  squash: load a bubble into the ID/EX register.
- wb_en  in  1  register write enable.
- wb_dest  in  4  write index.
- wb_value  in  DATA_W  write data.
- src1, src2  out  4  combinational source indices for the hazard unit.
- two_src, has_src1  out  1  combinational source-usage flags.
- ex_valid  out  1  registered: the ID/EX slot holds a live instruction.
- ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s  out  1  registered controls.
- ex_exe_cmd  out  4  registered ALU command.
- ex_val_rn, ex_val_rm, ex_pc  out  DATA_W  registered operands and PC.
- ex_imm  out  1  registered immediate flag.
- ex_shift_operand  out  12  registered shift operand.
- ex_signed_imm_24  out  24  registered branch offset.
- ex_dest  out  4  registered destination index.

Function
REQ-005 The decode SHALL use the following fields: cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12], Rm = [3:0].
REQ-006 In mode 00 the EXE_CMD mapping SHALL be:
- MOV 1101→0001, MVN 1111→1001
- ADD 0100→0010, ADC 0101→0011
- SUB 0010→0100, SBC 0110→0101
- AND 0000→0110, ORR 1100→0111, EOR 0001→1000
- CMP 1010→0100, TST 1000→0110
- wb_en = 1 except for CMP/TST; s = S bit, except CMP/TST force s = 1.
REQ-007 Mode 01 SHALL decode as follows:
- EXE_CMD = 0010.
- S = 1 is LDR: mem_r_en = 1, wb_en = 1.
- S = 0 is STR: mem_w_en = 1.
REQ-008 Mode 10 SHALL set b = 1 with all other controls 0; any other encoding SHALL decode as a NOP (all controls 0).
REQ-009 has_src1 SHALL be 0 for MOV, MVN and branch, and 1 otherwise.
REQ-010 Source selection SHALL follow these rules:
- src1 = Rn.
- src2 = Rd when the decoded instruction is STR, else Rm.
- two_src = ~I OR STR.
REQ-011 The condition check SHALL cover codes 0000..1110 (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL) per the ARM definitions; 1111 SHALL evaluate false.
REQ-012 A failing condition, or in_valid = 0, SHALL zero every control output loaded into ID/EX.
REQ-013 The register file SHALL have 2 combinational read ports and 1 write port written on the rising edge when wb_en = 1.
REQ-014 When WB_BYPASS = 1 and wb_en = 1, a read whose index equals wb_dest SHALL return wb_value in that same cycle.
REQ-015 Latency from instruction input to ex_* outputs SHALL be one clock.
REQ-016 Edge priority SHALL be flush > stall > load:
- flush = 1: ex_valid = 0 and all controls 0; data fields are don't-care but zeroed.
- stall = 1 with flush = 0: all ex_* hold.
- otherwise: load the decoded values.
REQ-017 Register-file writes SHALL proceed regardless of stall and flush.

Reset
REQ-018 While rst = 0, all ex_* outputs and every register-file entry SHALL be 0 asynchronously.
REQ-019 A reset asserted mid-stall SHALL clear held state, and the first load after rst rises SHALL occur on the next rising edge.

Structure
REQ-020 A shared package SHALL hold the EXE_CMD encodings, opcode and mode constants, the condition-code constants, and the SR bit positions.
REQ-021 The combinational decoder SHALL be one sub-module, decode_ctrl; the register file and the condition check SHALL stay inline.

Verification
REQ-022 After reset, a write of 0x1234 to R3, then ADD R1,R3,R3 (0xE0831003) with in_valid = 1 SHALL give, after 1 clock, ex_val_rn = ex_val_rm = 0x1234, ex_exe_cmd = 0010, ex_wb_en = 1, ex_dest = 1.
REQ-023 Bypass with WB_BYPASS = 1: wb_en = 1, wb_dest = 2, wb_value = 0xAA in the same cycle as SUB using R2 SHALL give ex_val_rn = 0xAA after 1 clock; with WB_BYPASS = 0 the result SHALL be the old value.
REQ-024 With sr = 0100 (Z = 1), BNE SHALL load ex_b = 0, and BEQ SHALL load ex_b = 1; cond 1111 SHALL load all controls 0.
REQ-025 stall held for 3 cycles SHALL keep ex_* unchanged while a write to R5 still lands; flush SHALL give ex_valid = 0 on the next edge even if stall = 1.
REQ-026 STR R4,[R1] SHALL give src2 = 4, two_src = 1, ex_mem_w_en = 1; MOV R0,#5 SHALL give has_src1 = 0, two_src = 0.
REQ-027 Reset asserted mid-operation SHALL zero the outputs immediately, before any clock edge.
